// File: rtl/search_scheduler_pkg.sv
// Shared types and constants for the motion search scheduler: FSM states,
// datapath widths and the column/row to motion-vector mapping.
package search_scheduler_pkg;

  localparam int SAD_W       = 18;
  localparam int MVX_W       = 6;
  localparam int MVY_W       = 8;
  localparam int COL_W       = 5;
  localparam int ROW_W       = 7;
  localparam int MV_X_OFFSET = 16;
  localparam int MV_Y_OFFSET = 64;

  typedef enum logic [2:0] {
    IDLE,
    PREP_REF,
    WAIT_CURR,
    PREP_PE,
    SEARCH,
    DRAIN,
    DONE
  } state_t;

  // Vectors wrap to the port width; the counters are never clamped.
  function automatic logic [MVX_W-1:0] col_to_mv(input logic [COL_W-1:0] col);
    return {1'b0, col} - MVX_W'(MV_X_OFFSET);
  endfunction

  function automatic logic [MVY_W-1:0] row_to_mv(input logic [ROW_W-1:0] row);
    return {1'b0, row} - MVY_W'(MV_Y_OFFSET);
  endfunction

endpackage

// File: rtl/search_scheduler_sad_min_tracker.sv
// Candidate pipeline that lines search positions up with their SAD results,
// plus the running-minimum comparator and its captured motion vector.
module sad_min_tracker
  import search_scheduler_pkg::*;
#(
  parameter int SAD_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             init,
  input  logic             push_valid,
  input  logic [COL_W-1:0] push_col,
  input  logic [ROW_W-1:0] push_row,
  input  logic [SAD_W-1:0] sad,
  output logic [SAD_W-1:0] min_sad,
  output logic [MVX_W-1:0] min_mv_x,
  output logic [MVY_W-1:0] min_mv_y
);

  logic [SAD_LAT-1:0] valid_pipe;
  logic [COL_W-1:0]   col_pipe [SAD_LAT];
  logic [ROW_W-1:0]   row_pipe [SAD_LAT];
  logic               out_valid;

  assign out_valid = valid_pipe[SAD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_pipe <= '0;
      for (int i = 0; i < SAD_LAT; i++) begin
        col_pipe[i] <= '0;
        row_pipe[i] <= '0;
      end
    end else begin
      valid_pipe[0] <= push_valid;
      col_pipe[0]   <= push_col;
      row_pipe[0]   <= push_row;
      for (int i = 1; i < SAD_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        col_pipe[i]   <= col_pipe[i-1];
        row_pipe[i]   <= row_pipe[i-1];
      end
    end
  end

  // Strictly-less update so that ties keep the earliest position.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      min_sad  <= '1;
      min_mv_x <= '0;
      min_mv_y <= '0;
    end else if (out_valid && (sad < min_sad)) begin
      min_sad  <= sad;
      min_mv_x <= col_to_mv(col_pipe[SAD_LAT-1]);
      min_mv_y <= row_to_mv(row_pipe[SAD_LAT-1]);
    end
  end

endmodule

// File: rtl/search_scheduler.sv
// Sequences one CTB search: reference preload, PE prepare, the position scan,
// pipeline drain and result publication, with abort and reset handling.
module search_scheduler
  import search_scheduler_pkg::*;
#(
  parameter int REF_PRELOAD = 8,
  parameter int SAD_LAT     = 3,
  parameter int COL_LAST    = 31,
  parameter int ROW_LAST    = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             curr_ready,
  input  logic [COL_W-1:0] search_column_count,
  input  logic [ROW_W-1:0] search_row_count,
  input  logic [SAD_W-1:0] SAD32x32,
  output logic             ref_begin_prepare,
  output logic             pe_begin_prepare,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [SAD_W-1:0] best_sad,
  output logic [MVX_W-1:0] best_mv_x,
  output logic [MVY_W-1:0] best_mv_y
);

  state_t           state;
  state_t           state_next;
  logic [15:0]      cnt;
  logic             abort_hit;
  logic             finish;
  logic             last_position;
  logic [SAD_W-1:0] run_sad;
  logic [MVX_W-1:0] run_mv_x;
  logic [MVY_W-1:0] run_mv_y;

  assign abort_hit     = abort && (state != IDLE);
  assign finish        = (state == DONE) && !abort;
  assign last_position = (search_column_count == COL_W'(COL_LAST)) &&
                         (search_row_count == ROW_W'(ROW_LAST));

  // cnt measures time spent in the current state; it restarts on every change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? 16'd0 : cnt + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = PREP_REF;
      PREP_REF:  if (cnt == 16'(REF_PRELOAD - 1))
                   state_next = curr_ready ? PREP_PE : WAIT_CURR;
      WAIT_CURR: if (curr_ready) state_next = PREP_PE;
      PREP_PE:   state_next = SEARCH;
      SEARCH:    if (last_position) state_next = DRAIN;
      DRAIN:     if (cnt == 16'(SAD_LAT - 1)) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  assign ref_begin_prepare = (state == PREP_REF) && (cnt == 16'd0);
  assign pe_begin_prepare  = (state == PREP_PE);
  assign busy              = (state != IDLE);

  // done and aborted appear together with the settled results, in the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      aborted   <= 1'b0;
      best_sad  <= '0;
      best_mv_x <= '0;
      best_mv_y <= '0;
    end else begin
      done    <= finish;
      aborted <= abort_hit;
      if (finish) begin
        best_sad  <= run_sad;
        best_mv_x <= run_mv_x;
        best_mv_y <= run_mv_y;
      end
    end
  end

  sad_min_tracker #(
    .SAD_LAT(SAD_LAT)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort_hit),
    .init      (state == PREP_REF),
    .push_valid(state == SEARCH),
    .push_col  (search_column_count),
    .push_row  (search_row_count),
    .sad       (SAD32x32),
    .min_sad   (run_sad),
    .min_mv_x  (run_mv_x),
    .min_mv_y  (run_mv_y)
  );

endmodule

// File: tb/tb_search_scheduler.sv
// Self-checking bench for search_scheduler: directed and randomized searches
// compared against a list-based minimum-search model.
module tb_search_scheduler;
  import search_scheduler_pkg::*;

  localparam int REF_PRELOAD = 8;
  localparam int SAD_LAT     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             curr_ready;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [SAD_W-1:0] sad;
  logic             ref_begin_prepare;
  logic             pe_begin_prepare;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [SAD_W-1:0] best_sad;
  logic [MVX_W-1:0] best_mv_x;
  logic [MVY_W-1:0] best_mv_y;

  int vectors     = 0;
  int miscompares = 0;
  int pos_col[$];
  int pos_row[$];
  int sad_list[$];
  int held_sad    = 0;
  int held_mv_x   = 0;
  int held_mv_y   = 0;

  search_scheduler #(
    .REF_PRELOAD(REF_PRELOAD),
    .SAD_LAT    (SAD_LAT),
    .COL_LAST   (31),
    .ROW_LAST   (63)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .curr_ready         (curr_ready),
    .search_column_count(col),
    .search_row_count   (row),
    .SAD32x32           (sad),
    .ref_begin_prepare  (ref_begin_prepare),
    .pe_begin_prepare   (pe_begin_prepare),
    .busy               (busy),
    .done               (done),
    .aborted            (aborted),
    .best_sad           (best_sad),
    .best_mv_x          (best_mv_x),
    .best_mv_y          (best_mv_y)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    checkOutput({tag, "_sad"},  32'(best_sad),  held_sad);
    checkOutput({tag, "_mvx"},  32'(best_mv_x), held_mv_x);
    checkOutput({tag, "_mvy"},  32'(best_mv_y), held_mv_y);
  endtask

  // Reference: scan the list in order, keep the first strict minimum.
  task automatic compute_expected(output int bs, output int bx, output int by);
    bs = 32'h3FFFF;
    bx = 0;
    by = 0;
    for (int i = 0; i < sad_list.size(); i++) begin
      if (sad_list[i] < bs) begin
        bs = sad_list[i];
        bx = (pos_col[i] - MV_X_OFFSET) & 32'h3F;
        by = (pos_row[i] - MV_Y_OFFSET) & 32'hFF;
      end
    end
  endtask

  task automatic build_list(input int n, input int fixed_sad, input int max_sad);
    int c, r;
    pos_col.delete();
    pos_row.delete();
    sad_list.delete();
    for (int i = 0; i < n - 1; i++) begin
      c = $urandom_range(0, 31);
      r = $urandom_range(0, 127);
      if (c == 31 && r == 63) r = 62;
      pos_col.push_back(c);
      pos_row.push_back(r);
      sad_list.push_back(fixed_sad >= 0 ? fixed_sad : int'($urandom_range(0, max_sad)));
    end
    pos_col.push_back(31);
    pos_row.push_back(63);
    sad_list.push_back(fixed_sad >= 0 ? fixed_sad : int'($urandom_range(0, max_sad)));
  endtask

  // One search: start, wait for PE prepare, feed positions and delayed SADs.
  task automatic applyStimulus(input int ready_delay, input int abort_at, input int rst_at,
                               input bit extra_start);
    int rel, pe_cyc, n, bs, bx, by;
    n = pos_col.size();
    curr_ready = (ready_delay == 0);
    start = 1'b1;
    tick();
    rel = 1;
    start = 1'b0;
    checkOutput("ref_pulse", 32'(ref_begin_prepare), 1);
    checkOutput("busy_prep", 32'(busy), 1);
    pe_cyc = -1;
    for (int t = 0; t < 200 && pe_cyc < 0; t++) begin
      if (pe_begin_prepare === 1'b1) begin
        pe_cyc = rel;
      end else begin
        start = extra_start && (rel == 3);
        if (rel >= REF_PRELOAD + ready_delay) curr_ready = 1'b1;
        tick();
        rel++;
        if (rel == REF_PRELOAD) checkOutput("busy_wait", 32'(busy), 1);
      end
    end
    start = 1'b0;
    checkOutput("pe_cycle", pe_cyc, 1 + REF_PRELOAD + ready_delay);
    if (pe_cyc < 0) return;

    for (int k = 0; k < n + SAD_LAT; k++) begin
      tick();
      if (k == 0) checkOutput("busy_search", 32'(busy), 1);
      col = (k < n) ? COL_W'(pos_col[k]) : COL_W'($urandom_range(0, 31));
      row = (k < n) ? ROW_W'(pos_row[k]) : ROW_W'($urandom_range(0, 127));
      sad = (k >= SAD_LAT) ? SAD_W'(sad_list[k - SAD_LAT]) : SAD_W'($urandom_range(0, 3));
      if (k == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("aborted_pulse", 32'(aborted), 1);
        checkOutput("busy_after_abort", 32'(busy), 0);
        check_held("abort_best");
        for (int j = 0; j < SAD_LAT + 4; j++) begin
          tick();
          checkOutput("no_done_after_abort", 32'(done), 0);
        end
        checkOutput("aborted_once", 32'(aborted), 0);
        check_held("abort_best_late");
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held_sad  = 0;
        held_mv_x = 0;
        held_mv_y = 0;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_aborted", 32'(aborted), 0);
        checkOutput("rst_ref", 32'(ref_begin_prepare), 0);
        checkOutput("rst_pe", 32'(pe_begin_prepare), 0);
        check_held("rst_best");
        tick();
        checkOutput("rst_stays_idle", 32'(busy), 0);
        return;
      end
    end
    tick();
    checkOutput("busy_done_state", 32'(busy), 1);
    tick();
    compute_expected(bs, bx, by);
    held_sad  = bs;
    held_mv_x = bx;
    held_mv_y = by;
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("idle_after_done", 32'(busy), 0);
    check_held("result");
    tick();
    checkOutput("done_single", 32'(done), 0);
    checkOutput("not_requeued", 32'(busy), 0);
    check_held("result_hold");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    curr_ready = 1'b1;
    col = '0;
    row = '0;
    sad = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_aborted", 32'(aborted), 0);
    checkOutput("reset_ref", 32'(ref_begin_prepare), 0);
    checkOutput("reset_pe", 32'(pe_begin_prepare), 0);
    check_held("reset_best");
    tick();

    $display("[TB] single minimum at col 20 row 70");
    build_list(20, 1000, 0);
    pos_col[7] = 20;
    pos_row[7] = 70;
    sad_list[7] = 5;
    applyStimulus(0, -1, -1, 1'b0);
    checkOutput("min_sad_5", 32'(best_sad), 5);
    checkOutput("min_mvx_4", 32'(best_mv_x), 4);
    checkOutput("min_mvy_6", 32'(best_mv_y), 6);

    $display("[TB] tie, delayed curr_ready, start while busy");
    build_list(16, 1000, 0);
    pos_col[2] = 3;
    pos_row[2] = 2;
    sad_list[2] = 7;
    pos_col[9] = 9;
    pos_row[9] = 40;
    sad_list[9] = 7;
    applyStimulus(10, -1, -1, 1'b1);
    checkOutput("tie_mvx", 32'(best_mv_x), 32'h33);
    checkOutput("tie_mvy", 32'(best_mv_y), 32'hC2);

    $display("[TB] abort after a completed search");
    build_list(20, 1000, 0);
    pos_col[7] = 20;
    pos_row[7] = 70;
    sad_list[7] = 5;
    applyStimulus(0, -1, -1, 1'b0);
    build_list(24, -1, 50);
    applyStimulus(0, 5, -1, 1'b0);
    checkOutput("abort_keeps_5", 32'(best_sad), 5);

    $display("[TB] randomized searches");
    for (int r = 0; r < 8; r++) begin
      build_list($urandom_range(2, 40), -1, (r % 2 == 0) ? 20 : 32'h3FFFE);
      applyStimulus($urandom_range(0, 3), -1, -1, 1'(r % 3 == 0));
    end

    $display("[TB] reset mid-search");
    build_list(30, -1, 100);
    applyStimulus(0, -1, 6, 1'b1);

    build_list($urandom_range(5, 20), -1, 20);
    applyStimulus(1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
